// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline sequencer for the 5-stage RV32I core
//   Generates load-use bubbles, redirect flushes, dmem freeze and timeout error.
//   Optional HAZARD_PERF_EN adds stall_cycles / flush_count counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_pc_src,
  input  logic       mem_dmem_req,
  input  logic       mem_dmem_ack,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       stall_execute,
  output logic       stall_memory,
  output logic       flush_decode,
  output logic       flush_execute,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mem_wait;
  logic mem_freeze;
  logic redirect;
  logic load_use;

  always_comb begin
    mem_wait   = mem_dmem_req & ~mem_dmem_ack;
    mem_freeze = mem_wait | (state_q == ST_ERROR);
    redirect   = ex_pc_src & ~mem_freeze;
    // x0 is never a real producer, so a load targeting it cannot create a hazard
    load_use   = ex_is_load & (ex_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) |
                  (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (mem_wait) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_dmem_ack) begin
          state_d = ST_RUN;
        end else begin
          if (wait_cnt_q == TIMEOUT_LAST) begin
            state_d   = ST_ERROR;
            mem_err_d = 1'b1;
          end
          if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    stall_execute = 1'b0;
    stall_memory  = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    if (!rst) begin
      flush_decode  = 1'b1;
      flush_execute = 1'b1;
    end else if (mem_freeze) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      stall_memory  = 1'b1;
    end else if (redirect) begin
      flush_decode  = 1'b1;
      flush_execute = 1'b1;
    end else if (load_use) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      flush_execute = 1'b1;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        any_stall;

  always_comb begin
    any_stall      = stall_fetch | stall_decode | stall_execute | stall_memory;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (any_stall) stall_cycles_d = stall_cycles_q + 32'd1;
    if (redirect)  flush_count_d  = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_pc_src;
  logic       mem_dmem_req, mem_dmem_ack;
  logic       stall_fetch, stall_decode, stall_execute, stall_memory;
  logic       flush_decode, flush_execute, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_pc_src     (ex_pc_src),
    .mem_dmem_req  (mem_dmem_req),
    .mem_dmem_ack  (mem_dmem_ack),
    .stall_fetch   (stall_fetch),
    .stall_decode  (stall_decode),
    .stall_execute (stall_execute),
    .stall_memory  (stall_memory),
    .flush_decode  (flush_decode),
    .flush_execute (flush_execute),
    .mem_err       (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_fetch, stall_decode, stall_execute, stall_memory, flush_decode, flush_execute, mem_err}
  logic [6:0] outs;
  assign outs = {stall_fetch, stall_decode, stall_execute, stall_memory,
                 flush_decode, flush_execute, mem_err};

  localparam logic [6:0] IDLE   = 7'b0000_000;
  localparam logic [6:0] LU     = 7'b1100_010;
  localparam logic [6:0] FLUSH  = 7'b0000_110;
  localparam logic [6:0] FREEZE = 7'b1111_000;
  localparam logic [6:0] ERR    = 7'b1111_001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // sample at negedge, then advance to just after the next posedge
  task automatic expect_out(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk(tag, {25'd0, outs}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string tag);
    @(negedge clk);
    chk(tag, {26'd0, outs[6:1]}, {26'd0, FLUSH[6:1]});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_pc_src = 1'b0;
    mem_dmem_req = 1'b0; mem_dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    expect_reset("reset_outputs");
    rst = 1'b1;
    expect_out("idle_after_reset", IDLE);

    // lw x5 in ex, add x6,x5,x7 in decode
    ex_is_load = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    expect_out("load_use_rs1", LU);
    ex_is_load = 1'b0; ex_rd = 5'd6;
    expect_out("load_use_cleared", IDLE);

    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    expect_out("x0_no_stall", IDLE);
    ex_rd = 5'd5; id_rs1 = 5'd1; id_use_rs1 = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
    expect_out("rs2_unused_no_stall", IDLE);
    id_use_rs2 = 1'b1;
    expect_out("load_use_rs2", LU);

    // redirect outranks load-use
    ex_pc_src = 1'b1;
    expect_out("redirect_over_lu", FLUSH);
    clear_inputs();
    expect_out("idle_after_redirect", IDLE);

    mem_dmem_req = 1'b1; mem_dmem_ack = 1'b1;
    expect_out("zero_wait_access", IDLE);

    // 3-cycle dmem wait with a redirect held behind the freeze
    mem_dmem_ack = 1'b0;
    expect_out("freeze_1", FREEZE);
    ex_pc_src = 1'b1;
    expect_out("freeze_2_redirect_held", FREEZE);
    expect_out("freeze_3", FREEZE);
    mem_dmem_ack = 1'b1;
    expect_out("ack_applies_redirect", FLUSH);
    clear_inputs();
    expect_out("run_after_ack", IDLE);

    // timeout: RUN cycle + 16 MEM_WAIT cycles without error, then ERROR
    mem_dmem_req = 1'b1;
    for (int i = 0; i < 17; i++) expect_out($sformatf("wait_no_err_%0d", i), FREEZE);
    expect_out("timeout_error", ERR);
    clear_inputs();
    expect_out("error_sticky_frozen", ERR);
    ex_pc_src = 1'b1;
    expect_out("error_over_redirect", ERR);
    clear_inputs();
    rst = 1'b0;
    expect_reset("reset_in_error");
    rst = 1'b1;
    expect_out("error_cleared", IDLE);

    // reset mid-wait abandons the access
    mem_dmem_req = 1'b1;
    expect_out("wait_before_reset", FREEZE);
    expect_out("wait_before_reset_2", FREEZE);
    mem_dmem_req = 1'b0;
    rst = 1'b0;
    expect_reset("reset_mid_wait");
    rst = 1'b1;
    expect_out("idle_after_abandon", IDLE);

`ifdef HAZARD_PERF_EN
    rst = 1'b0;
    expect_reset("perf_reset");
    rst = 1'b1;
    @(negedge clk);
    chk("perf_stall_reset", stall_cycles, 32'd0);
    chk("perf_flush_reset", flush_count, 32'd0);
    @(posedge clk); #1;
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    expect_out("perf_lu", LU);
    clear_inputs();
    ex_pc_src = 1'b1;
    expect_out("perf_redirect", FLUSH);
    clear_inputs();
    mem_dmem_req = 1'b1; mem_dmem_ack = 1'b1;
    expect_out("perf_zero_wait", IDLE);
    clear_inputs();
    @(negedge clk);
    chk("perf_stall_cycles", stall_cycles, 32'd1);
    chk("perf_flush_count", flush_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
